// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one single-port data RAM between the CPU MEM stage
//             (primary) and a DMA/debug loader port (secondary). The CPU owns
//             the RAM by default. A waiting DMA request is granted for one
//             cycle as soon as the CPU is idle, or after a bounded wait.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low

    input  logic              cpu_mem_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int              CNT_W      = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    // Grant state and wait counter registers; reset drops any DMA grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= GNT_CPU;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next grant: DMA wins when the CPU is idle or the wait bound is reached;
    // a DMA grant always lasts exactly one cycle.
    always_comb begin
        state_d    = GNT_CPU;
        wait_cnt_d = '0;
        case (state_q)
            GNT_CPU: begin
                if (dma_req && (!cpu_mem_req || wait_cnt_q == C_CNT_LAST)) begin
                    state_d    = GNT_DMA;
                    wait_cnt_d = '0;
                end else if (dma_req && cpu_mem_req) begin
                    state_d    = GNT_CPU;
                    // Saturating increment; the grant rule above normally
                    // fires before the limit is exceeded.
                    wait_cnt_d = (wait_cnt_q == C_CNT_LAST) ? wait_cnt_q
                                                            : wait_cnt_q + 1'b1;
                end else begin
                    state_d    = GNT_CPU;
                    wait_cnt_d = '0;
                end
            end
            GNT_DMA: begin
                state_d    = GNT_CPU;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = GNT_CPU;
                wait_cnt_d = '0;
            end
        endcase
    end

    // RAM mux and handshake outputs; the stall depends only on the registered
    // grant and cpu_mem_req, never on dma_req.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we & cpu_mem_req;
        cpu_stall = 1'b0;
        dma_ack   = 1'b0;
        if (state_q == GNT_DMA) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_we & dma_req;
            cpu_stall = cpu_mem_req;
            dma_ack   = dma_req;
        end
        // No write may reach the RAM while reset is held.
        if (!rst) begin
            ram_we    = 1'b0;
            cpu_stall = 1'b0;
            dma_ack   = 1'b0;
        end
    end

    assign cpu_rdata = ram_rdata;
    assign dma_rdata = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a
//             behavioural single-port RAM (async read, write on rising edge).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_mem_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:65535];

    int n_checks;
    int n_pass;

    dmem_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_mem_req(cpu_mem_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;

        // ---------------- Reset with a pending CPU store ----------------
        rst         = 1'b0;
        cpu_mem_req = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 16'h0010;
        cpu_wdata   = 16'hBEEF;
        dma_req     = 1'b0;
        dma_we      = 1'b0;
        dma_addr    = 16'h0000;
        dma_wdata   = 16'h0000;
        #2;
        chk("rst_ram_we",  32'(ram_we),    32'h0);
        chk("rst_dma_ack", 32'(dma_ack),   32'h0);
        chk("rst_stall",   32'(cpu_stall), 32'h0);
        chk("rst_addr",    32'(ram_addr),  32'h0010);
        next_cycle();
        next_cycle();
        #1;
        chk("rst_no_write", 32'(mem[16'h0010]), 32'h0);

        // Release: CPU store lands
        rst = 1'b1;
        #1;
        chk("rel_ram_we", 32'(ram_we),    32'h1);
        chk("rel_stall",  32'(cpu_stall), 32'h0);
        next_cycle();
        cpu_mem_req = 1'b0;
        cpu_we      = 1'b0;
        #1;
        chk("cpu_store", 32'(mem[16'h0010]), 32'hBEEF);
        next_cycle();

        // ---------------- Idle DMA write then read ----------------
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'h0040;
        dma_wdata = 16'h1234;
        #1;
        chk("dw_c0_ack", 32'(dma_ack), 32'h0);
        chk("dw_c0_we",  32'(ram_we),  32'h0);
        next_cycle();
        #1;
        chk("dw_c1_ack",  32'(dma_ack),   32'h1);
        chk("dw_c1_we",   32'(ram_we),    32'h1);
        chk("dw_c1_addr", 32'(ram_addr),  32'h0040);
        chk("dw_c1_stall",32'(cpu_stall), 32'h0);
        next_cycle();
        dma_we = 1'b0;
        #1;
        chk("dr_c2_ack", 32'(dma_ack),        32'h0);
        chk("dw_mem",    32'(mem[16'h0040]),  32'h1234);
        next_cycle();
        #1;
        chk("dr_c3_ack",   32'(dma_ack),   32'h1);
        chk("dr_c3_rdata", 32'(dma_rdata), 32'h1234);
        chk("dr_c3_we",    32'(ram_we),    32'h0);
        next_cycle();
        dma_req = 1'b0;

        // ---------------- Starvation bound (MAX_WAIT=4) ----------------
        cpu_mem_req = 1'b1;
        cpu_we      = 1'b1;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_addr    = 16'h0200;
        dma_wdata   = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            cpu_addr  = 16'h0100 + 16'(i);
            cpu_wdata = 16'hA000 + 16'(i);
            #1;
            chk("sv_wait_ack",   32'(dma_ack),   32'h0);
            chk("sv_wait_stall", 32'(cpu_stall), 32'h0);
            chk("sv_wait_addr",  32'(ram_addr),  32'(16'h0100 + 16'(i)));
            next_cycle();
        end
        cpu_addr  = 16'h0104;
        cpu_wdata = 16'hA004;
        #1;
        chk("sv_c4_ack",   32'(dma_ack),   32'h1);
        chk("sv_c4_stall", 32'(cpu_stall), 32'h1);
        chk("sv_c4_addr",  32'(ram_addr),  32'h0200);
        chk("sv_c4_we",    32'(ram_we),    32'h1);
        next_cycle();
        dma_req = 1'b0;
        #1;
        chk("sv_c5_stall",  32'(cpu_stall),      32'h0);
        chk("sv_c5_ack",    32'(dma_ack),        32'h0);
        chk("sv_c5_addr",   32'(ram_addr),       32'h0104);
        chk("sv_no_early",  32'(mem[16'h0104]),  32'h0);
        chk("sv_dma_mem",   32'(mem[16'h0200]),  32'h5555);
        chk("sv_cpu_prev",  32'(mem[16'h0103]),  32'hA003);
        next_cycle();
        cpu_mem_req = 1'b0;
        cpu_we      = 1'b0;
        #1;
        chk("sv_retry_mem", 32'(mem[16'h0104]), 32'hA004);
        next_cycle();

        // ---------------- Back-to-back DMA, CPU idle ----------------
        for (int k = 0; k < 6; k++) begin
            dma_req   = 1'b1;
            dma_we    = 1'b1;
            dma_addr  = 16'h0300 + 16'(k);
            dma_wdata = 16'hC000 + 16'(k);
            #1;
            chk("bb_gap_ack", 32'(dma_ack), 32'h0);
            chk("bb_gap_we",  32'(ram_we),  32'h0);
            next_cycle();
            #1;
            chk("bb_ack",  32'(dma_ack),  32'h1);
            chk("bb_we",   32'(ram_we),   32'h1);
            chk("bb_addr", 32'(ram_addr), 32'(16'h0300 + 16'(k)));
            next_cycle();
        end
        dma_req = 1'b0;
        dma_we  = 1'b0;
        #1;
        chk("bb_mem0", 32'(mem[16'h0300]), 32'hC000);
        chk("bb_mem5", 32'(mem[16'h0305]), 32'hC005);
        next_cycle();

        // ---------------- Counter clear on request drop ----------------
        cpu_mem_req = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 16'h0010;
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_addr    = 16'h0040;
        #1;
        chk("cc_c0_rdata", 32'(cpu_rdata), 32'hBEEF);
        chk("cc_c0_ack",   32'(dma_ack),   32'h0);
        next_cycle();
        #1;
        chk("cc_c1_ack", 32'(dma_ack), 32'h0);
        next_cycle();
        dma_req = 1'b0;
        #1;
        chk("cc_c2_ack", 32'(dma_ack), 32'h0);
        next_cycle();
        dma_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cc_wait_ack",   32'(dma_ack),   32'h0);
            chk("cc_wait_stall", 32'(cpu_stall), 32'h0);
            next_cycle();
        end
        #1;
        chk("cc_c7_ack",   32'(dma_ack),   32'h1);
        chk("cc_c7_stall", 32'(cpu_stall), 32'h1);
        chk("cc_c7_rdata", 32'(dma_rdata), 32'h1234);
        next_cycle();
        dma_req     = 1'b0;
        cpu_mem_req = 1'b0;
        #1;
        chk("cc_c8_stall", 32'(cpu_stall), 32'h0);
        next_cycle();

        // ---------------- Request dropped during grant ----------------
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'h0500;
        dma_wdata = 16'h7777;
        #1;
        chk("pv_c0_ack", 32'(dma_ack), 32'h0);
        next_cycle();
        dma_req = 1'b0;
        #1;
        chk("pv_c1_ack", 32'(dma_ack), 32'h0);
        chk("pv_c1_we",  32'(ram_we),  32'h0);
        next_cycle();
        cpu_mem_req = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 16'h0010;
        #1;
        chk("pv_c2_stall", 32'(cpu_stall),     32'h0);
        chk("pv_c2_addr",  32'(ram_addr),      32'h0010);
        chk("pv_c2_rdata", 32'(cpu_rdata),     32'hBEEF);
        chk("pv_no_write", 32'(mem[16'h0500]), 32'h0);
        next_cycle();
        cpu_mem_req = 1'b0;

        // ---------------- Reset asserted mid-grant ----------------
        dma_req   = 1'b1;
        dma_we    = 1'b1;
        dma_addr  = 16'h0400;
        dma_wdata = 16'hDEAD;
        cpu_addr  = 16'h0055;
        #1;
        chk("rg_c0_ack", 32'(dma_ack), 32'h0);
        next_cycle();
        #1;
        chk("rg_c1_ack_pre", 32'(dma_ack), 32'h1);
        rst = 1'b0;
        #1;
        chk("rg_rst_ack",  32'(dma_ack),  32'h0);
        chk("rg_rst_we",   32'(ram_we),   32'h0);
        chk("rg_rst_addr", 32'(ram_addr), 32'h0055);
        next_cycle();
        dma_req = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rg_no_write", 32'(mem[16'h0400]), 32'h0);
        chk("rg_cpu_addr", 32'(ram_addr),      32'h0055);
        chk("rg_post_ack", 32'(dma_ack),       32'h0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
